// File: rtl/vp_exec_pkg.sv
// Shared types and constants for the vector-processor execute stage.
package vp_exec_pkg;

    localparam int unsigned LANES   = 24;
    localparam int unsigned LANE_W  = 8;
    localparam int unsigned MUL_LPC = 4;

    localparam int unsigned EXEC_IMM_BIT = 4;
    localparam int unsigned EXEC_VEC_BIT = 3;
    localparam int unsigned EXEC_OP_MSB  = 2;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluXor = 3'b100,
        AluShl = 3'b101,
        AluShr = 3'b110,
        AluMul = 3'b111
    } alu_op_t;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StMul  = 1'b1
    } exec_state_t;

    typedef struct packed {
        logic [3:0] mem;
        logic [1:0] wb;
        logic [3:0] dest;
        logic       dest_type;
    } fwd_t;

endpackage

// File: rtl/vector_lane_alu.sv
// One combinational 8-bit lane ALU; sat_en_i selects unsigned saturation for ADD/SUB.
module vector_lane_alu
    import vp_exec_pkg::*;
(
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    input  alu_op_t           op_i,
    input  logic              sat_en_i,
    output logic [LANE_W-1:0] y_o
);

    logic [LANE_W:0] sum;
    logic [LANE_W:0] diff;
    logic [2:0]      shamt;

    always_comb begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        diff  = {1'b0, a_i} - {1'b0, b_i};
        shamt = b_i[2:0];
        y_o   = '0;
        unique case (op_i)
            AluAdd: y_o = (sat_en_i && sum[LANE_W]) ? '1 : sum[LANE_W-1:0];
            AluSub: y_o = (sat_en_i && diff[LANE_W]) ? '0 : diff[LANE_W-1:0];
            AluAnd: y_o = a_i & b_i;
            AluOr:  y_o = a_i | b_i;
            AluXor: y_o = a_i ^ b_i;
            AluShl: y_o = a_i << shamt;
            AluShr: y_o = a_i >> shamt;
            AluMul: y_o = a_i * b_i;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: scalar/vector lane ALUs, registered results, multi-cycle vector MUL.
// Define EXECUTE_SAT_EN for unsigned per-lane saturation of vector ADD/SUB.
module execute_stage #(
    parameter int unsigned LANES   = vp_exec_pkg::LANES,
    parameter int unsigned LANE_W  = vp_exec_pkg::LANE_W,
    parameter int unsigned MUL_LPC = vp_exec_pkg::MUL_LPC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [4:0]              exec,
    input  logic [3:0]              mem,
    input  logic [1:0]              wb,
    input  logic [LANE_W-1:0]       immALU,
    input  logic [LANE_W-1:0]       r1e,
    input  logic [LANE_W-1:0]       r2e,
    input  logic [LANES*LANE_W-1:0] r1v,
    input  logic [LANES*LANE_W-1:0] r2v,
    input  logic [3:0]              dest,
    input  logic                    destType_in,
    output logic [LANE_W-1:0]       res_s,
    output logic [LANES*LANE_W-1:0] res_v,
    output logic [LANE_W-1:0]       store_s,
    output logic [LANES*LANE_W-1:0] store_v,
    output logic [3:0]              mem_out,
    output logic [1:0]              wb_out,
    output logic [3:0]              dest_out,
    output logic                    destType_out,
    output logic                    valid_out,
    output logic                    stall
);
    import vp_exec_pkg::*;

    localparam int unsigned VecW     = LANES * LANE_W;
    localparam int unsigned MulSteps = LANES / MUL_LPC;
    localparam int unsigned KW       = (MulSteps > 1) ? $clog2(MulSteps) : 1;
    localparam logic [KW-1:0] KLast  = KW'(MulSteps - 1);

    exec_state_t       state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [VecW-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d, shadow_q, shadow_d;
    logic [VecW-1:0]   res_v_q, res_v_d, store_v_q, store_v_d, pend_store_v_q, pend_store_v_d;
    logic [LANE_W-1:0] res_s_q, res_s_d, store_s_q, store_s_d, pend_store_s_q, pend_store_s_d;
    fwd_t              fwd_q, fwd_d, pend_fwd_q, pend_fwd_d, fwd_in;
    logic              valid_q, valid_d;

    alu_op_t           op, vec_op;
    logic              in_mul, vec_mode, use_imm, vec_sat;
    logic [LANE_W-1:0] sc_b, sc_y;
    logic [VecW-1:0]   b_vec, vec_a, vec_b, vec_y;

`ifdef EXECUTE_SAT_EN
    assign vec_sat = 1'b1;
`else
    assign vec_sat = 1'b0;
`endif

    // While multiplying, the vector ALUs are fed from the latched operands, not the inputs.
    always_comb begin
        in_mul   = (state_q == StMul);
        op       = alu_op_t'(exec[EXEC_OP_MSB:0]);
        vec_mode = exec[EXEC_VEC_BIT];
        use_imm  = exec[EXEC_IMM_BIT];
        sc_b     = use_imm ? immALU : r2e;
        b_vec    = use_imm ? {LANES{immALU}} : r2v;
        vec_a    = in_mul ? mul_a_q : r1v;
        vec_b    = in_mul ? mul_b_q : b_vec;
        vec_op   = in_mul ? AluMul : op;
        fwd_in   = '{mem: mem, wb: wb, dest: dest, dest_type: destType_in};
    end

    vector_lane_alu u_scalar_alu (
        .a_i      (r1e),
        .b_i      (sc_b),
        .op_i     (op),
        .sat_en_i (1'b0),
        .y_o      (sc_y)
    );

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        vector_lane_alu u_lane_alu (
            .a_i      (vec_a[g*LANE_W +: LANE_W]),
            .b_i      (vec_b[g*LANE_W +: LANE_W]),
            .op_i     (vec_op),
            .sat_en_i (vec_sat),
            .y_o      (vec_y[g*LANE_W +: LANE_W])
        );
    end

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        mul_a_d        = mul_a_q;
        mul_b_d        = mul_b_q;
        shadow_d       = shadow_q;
        res_v_d        = res_v_q;
        res_s_d        = res_s_q;
        store_v_d      = store_v_q;
        store_s_d      = store_s_q;
        pend_store_v_d = pend_store_v_q;
        pend_store_s_d = pend_store_s_q;
        fwd_d          = fwd_q;
        pend_fwd_d     = pend_fwd_q;
        valid_d        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (valid_in) begin
                    if (vec_mode && op == AluMul) begin
                        state_d        = StMul;
                        k_d            = '0;
                        mul_a_d        = r1v;
                        mul_b_d        = b_vec;
                        pend_fwd_d     = fwd_in;
                        pend_store_s_d = r2e;
                        pend_store_v_d = r2v;
                    end else begin
                        valid_d   = 1'b1;
                        fwd_d     = fwd_in;
                        store_s_d = r2e;
                        store_v_d = r2v;
                        if (vec_mode) begin
                            res_v_d = vec_y;
                        end else begin
                            res_s_d = sc_y;
                        end
                    end
                end
            end
            StMul: begin
                for (int i = 0; i < int'(LANES); i++) begin
                    if (KW'(i / MUL_LPC) == k_q) begin
                        shadow_d[i*LANE_W +: LANE_W] = vec_y[i*LANE_W +: LANE_W];
                    end
                end
                if (k_q == KLast) begin
                    state_d   = StIdle;
                    k_d       = '0;
                    res_v_d   = shadow_d;
                    valid_d   = 1'b1;
                    fwd_d     = pend_fwd_q;
                    store_s_d = pend_store_s_q;
                    store_v_d = pend_store_v_q;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            k_q            <= '0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            shadow_q       <= '0;
            res_v_q        <= '0;
            res_s_q        <= '0;
            store_v_q      <= '0;
            store_s_q      <= '0;
            pend_store_v_q <= '0;
            pend_store_s_q <= '0;
            fwd_q          <= '0;
            pend_fwd_q     <= '0;
            valid_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
            shadow_q       <= shadow_d;
            res_v_q        <= res_v_d;
            res_s_q        <= res_s_d;
            store_v_q      <= store_v_d;
            store_s_q      <= store_s_d;
            pend_store_v_q <= pend_store_v_d;
            pend_store_s_q <= pend_store_s_d;
            fwd_q          <= fwd_d;
            pend_fwd_q     <= pend_fwd_d;
            valid_q        <= valid_d;
        end
    end

    assign res_s        = res_s_q;
    assign res_v        = res_v_q;
    assign store_s      = store_s_q;
    assign store_v      = store_v_q;
    assign mem_out      = fwd_q.mem;
    assign wb_out       = fwd_q.wb;
    assign dest_out     = fwd_q.dest;
    assign destType_out = fwd_q.dest_type;
    assign valid_out    = valid_q;
    assign stall        = (state_q == StMul);

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed test-plan cases plus randomized traffic
// compared every cycle against a behavioural model.
module tb_execute_stage;

    localparam int L = 24;
`ifdef EXECUTE_SAT_EN
    localparam bit Sat = 1'b1;
`else
    localparam bit Sat = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_in = 1'b0;
    logic [4:0]   exec = '0;
    logic [3:0]   mem = '0;
    logic [1:0]   wb = '0;
    logic [7:0]   imm_alu = '0, r1e = '0, r2e = '0;
    logic [191:0] r1v = '0, r2v = '0;
    logic [3:0]   dest = '0;
    logic         dest_type = 1'b0;

    logic [7:0]   res_s, store_s;
    logic [191:0] res_v, store_v;
    logic [3:0]   mem_out, dest_out;
    logic [1:0]   wb_out;
    logic         dest_type_out, valid_out, stall;

    execute_stage dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .exec         (exec),
        .mem          (mem),
        .wb           (wb),
        .immALU       (imm_alu),
        .r1e          (r1e),
        .r2e          (r2e),
        .r1v          (r1v),
        .r2v          (r2v),
        .dest         (dest),
        .destType_in  (dest_type),
        .res_s        (res_s),
        .res_v        (res_v),
        .store_s      (store_s),
        .store_v      (store_v),
        .mem_out      (mem_out),
        .wb_out       (wb_out),
        .dest_out     (dest_out),
        .destType_out (dest_type_out),
        .valid_out    (valid_out),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    logic [7:0]   m_res_s, m_store_s, m_pstore_s;
    logic [191:0] m_res_v, m_store_v, m_pstore_v, m_mul;
    logic [3:0]   m_mem, m_dest, m_pmem, m_pdest;
    logic [1:0]   m_wb, m_pwb;
    logic         m_dt, m_pdt, m_valid;
    int           m_busy;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_op(input int op, input int a, input int b, input bit sat);
        int r;
        case (op)
            0: begin r = a + b; if (sat && r > 255) r = 255; end
            1: begin r = a - b; if (sat && r < 0) r = 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a << (b % 8);
            6: r = a >> (b % 8);
            default: r = a * b;
        endcase
        return 8'(r & 255);
    endfunction

    task automatic model_step();
        int op, b;
        op = int'(exec[2:0]);
        if (rst) begin
            m_res_s = '0; m_store_s = '0; m_pstore_s = '0;
            m_res_v = '0; m_store_v = '0; m_pstore_v = '0; m_mul = '0;
            m_mem = '0; m_dest = '0; m_wb = '0; m_dt = 1'b0;
            m_valid = 1'b0; m_busy = 0;
        end else if (m_busy > 0) begin
            m_valid = 1'b0;
            m_busy--;
            if (m_busy == 0) begin
                m_res_v = m_mul; m_store_v = m_pstore_v; m_store_s = m_pstore_s;
                m_mem = m_pmem; m_wb = m_pwb; m_dest = m_pdest; m_dt = m_pdt;
                m_valid = 1'b1;
            end
        end else if (valid_in) begin
            if (exec[3] && op == 7) begin
                for (int i = 0; i < L; i++) begin
                    b = exec[4] ? int'(imm_alu) : int'(r2v[i*8 +: 8]);
                    m_mul[i*8 +: 8] = ref_op(7, int'(r1v[i*8 +: 8]), b, Sat);
                end
                m_pstore_v = r2v; m_pstore_s = r2e;
                m_pmem = mem; m_pwb = wb; m_pdest = dest; m_pdt = dest_type;
                m_busy = L / 4;
                m_valid = 1'b0;
            end else begin
                if (exec[3]) begin
                    for (int i = 0; i < L; i++) begin
                        b = exec[4] ? int'(imm_alu) : int'(r2v[i*8 +: 8]);
                        m_res_v[i*8 +: 8] = ref_op(op, int'(r1v[i*8 +: 8]), b, Sat);
                    end
                end else begin
                    m_res_s = ref_op(op, int'(r1e), exec[4] ? int'(imm_alu) : int'(r2e), 1'b0);
                end
                m_store_v = r2v; m_store_s = r2e;
                m_mem = mem; m_wb = wb; m_dest = dest; m_dt = dest_type;
                m_valid = 1'b1;
            end
        end else begin
            m_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid_out", {191'd0, valid_out}, {191'd0, m_valid});
            check("stall", {191'd0, stall}, {191'd0, (m_busy > 0)});
            check("res_s", {184'd0, res_s}, {184'd0, m_res_s});
            check("res_v", res_v, m_res_v);
            check("store_s", {184'd0, store_s}, {184'd0, m_store_s});
            check("store_v", store_v, m_store_v);
            check("fwd", {181'd0, mem_out, wb_out, dest_out, dest_type_out},
                  {181'd0, m_mem, m_wb, m_dest, m_dt});
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        valid_in  = ($urandom_range(0, 99) < 85);
        exec      = 5'($urandom);
        if ($urandom_range(0, 4) == 0) exec[3:0] = 4'b1111;
        mem       = 4'($urandom);
        wb        = 2'($urandom);
        imm_alu   = 8'($urandom);
        r1e       = 8'($urandom);
        r2e       = 8'($urandom);
        dest      = 4'($urandom);
        dest_type = 1'($urandom);
        for (int w = 0; w < 6; w++) begin
            r1v[w*32 +: 32] = $urandom;
            r2v[w*32 +: 32] = $urandom;
        end
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        step();
        step();
        chk_en = 1'b1;
        check("reset res_s", {184'd0, res_s}, 192'd0);
        check("reset stall", {191'd0, stall}, 192'd0);
        rst = 1'b0;

        // Scalar ADD with immediate
        valid_in = 1'b1; exec = 5'b10000; r1e = 8'hF0; imm_alu = 8'h20;
        mem = 4'hA; wb = 2'd2; dest = 4'h5; dest_type = 1'b0;
        step();
        check("scalar add res_s", {184'd0, res_s}, {184'd0, 8'h10});
        check("scalar add valid", {191'd0, valid_out}, 192'd1);
        check("scalar add fwd", {181'd0, mem_out, wb_out, dest_out, dest_type_out},
              {181'd0, 4'hA, 2'd2, 4'h5, 1'b0});

        // Vector SUB 5 - 7 in every lane
        exec = 5'b01001; r1v = {24{8'h05}}; r2v = {24{8'h07}};
        step();
        check("vec sub", res_v, Sat ? 192'd0 : {24{8'hFE}});
        check("vec sub keeps res_s", {184'd0, res_s}, {184'd0, 8'h10});

        // Vector SHL / SHR with per-lane shift amount
        for (int i = 0; i < L; i++) begin
            r1v[i*8 +: 8] = 8'h81;
            r2v[i*8 +: 8] = 8'(i);
        end
        exec = 5'b01101;
        step();
        check("shl lane0", {184'd0, res_v[7:0]}, {184'd0, 8'h81});
        check("shl lane1", {184'd0, res_v[15:8]}, {184'd0, 8'h02});
        check("shl lane7", {184'd0, res_v[63:56]}, {184'd0, 8'h80});
        exec = 5'b01110;
        step();
        check("shr lane1", {184'd0, res_v[15:8]}, {184'd0, 8'h40});
        check("shr lane7", {184'd0, res_v[63:56]}, {184'd0, 8'h01});
        check("shr lane9", {184'd0, res_v[79:72]}, {184'd0, 8'h40});

        // Vector MUL: lane i = i * 3
        for (int i = 0; i < L; i++) begin
            r1v[i*8 +: 8] = 8'(i);
            r2v[i*8 +: 8] = 8'd3;
        end
        exec = 5'b01111; mem = 4'h3; dest = 4'hC;
        step();
        check("mul stall start", {191'd0, stall}, 192'd1);
        check("mul no early valid", {191'd0, valid_out}, 192'd0);
        cnt = 1;
        while (stall === 1'b1 && cnt < 20) begin
            rand_inputs();
            step();
            if (stall === 1'b1) cnt++;
        end
        check("mul stall cycles", 192'(cnt), 192'd6);
        check("mul valid", {191'd0, valid_out}, 192'd1);
        check("mul lane23", {184'd0, res_v[191:184]}, {184'd0, 8'h45});
        check("mul lane10", {184'd0, res_v[87:80]}, {184'd0, 8'h1E});
        check("mul dest", {188'd0, dest_out}, {188'd0, 4'hC});
        valid_in = 1'b0;
        step();
        check("mul valid pulse", {191'd0, valid_out}, 192'd0);

        // Reset in the third stall cycle
        valid_in = 1'b1; exec = 5'b11111; imm_alu = 8'd3;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        check("rst mid-mul res_v", res_v, 192'd0);
        check("rst mid-mul stall", {191'd0, stall}, 192'd0);
        check("rst mid-mul valid", {191'd0, valid_out}, 192'd0);
        rst = 1'b0;
        valid_in = 1'b1; exec = 5'b00001; r1e = 8'd9; r2e = 8'd4;
        step();
        check("post-rst sub", {184'd0, res_s}, {184'd0, 8'd5});
        check("post-rst valid", {191'd0, valid_out}, 192'd1);

        // Bubble with garbage operands
        valid_in = 1'b0; exec = 5'b01000; r1e = 8'hAA; r1v = {24{8'h5A}};
        step();
        check("bubble valid", {191'd0, valid_out}, 192'd0);
        check("bubble res_s", {184'd0, res_s}, {184'd0, 8'd5});

        // Randomized traffic, occasional reset
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        valid_in = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the vector processor pipeline, placed directly downstream of the decode stage and upstream of the memory stage. It consumes the decoded control fields, immediate and scalar/vector operands, and computes an 8-bit scalar result or a 192-bit vector result (24 lanes × 8 bits). All results are registered. Vector multiply runs as a multi-cycle operation and stalls the front end while it is busy. Memory, write-back and destination fields are forwarded alongside the result.

## Interface
Parameters:
- LANES, 24, number of 8-bit vector lanes
- LANE_W, 8, lane and scalar width
- MUL_LPC, 4, vector-multiply lanes processed per cycle (must divide LANES)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  decode output holds a real instruction (0 = bubble)
- exec  in  5  [4] use immediate as B, [3] vector mode, [2:0] ALU op
- mem  in  4  memory-stage control, passed through
- wb  in  2  write-back control, passed through
- immALU  in  8  immediate
- r1e, r2e  in  8  scalar operands A, B
- r1v, r2v  in  192  vector operands A, B
- dest  in  4  destination register index
- destType_in  in  1  destination type (1 = vector)
- res_s  out  8  scalar result
- res_v  out  192  vector result
- store_s  out  8  r2e passed to the memory stage (store data)
- store_v  out  192  r2v passed to the memory stage
- mem_out, wb_out, dest_out, destType_out  out  4/2/4/1  registered pass-through
- valid_out  out  1  outputs hold a completed instruction
- stall  out  1  front end must hold fetch/decode; inputs are ignored while high

## Operation
- Ops in [2:0]: 000 ADD, 001 SUB (A−B), 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
- B source: immALU when exec[4]=1; in vector mode the immediate is broadcast to all lanes.
- Lanes are independent and carries never cross lane boundaries.
- Shift amount is B[2:0] of the same lane.
- MUL keeps product bits [7:0].
- Scalar mode computes only res_s; res_v holds its previous value. Vector mode mirrors the previous res_s in the same way.
- FSM states:
  - IDLE: accepts an instruction when valid_in=1.
  - MUL: entered only for vector MUL.
- Transitions:
  - IDLE→MUL on an accepted vector MUL. The operands are latched and the lane counter is set to 0.
  - MUL: each cycle computes lanes [4k..4k+3] into the result shadow, then k increments. After k=5 the result registers and the FSM returns to IDLE.
- Inputs (including valid_in) are ignored in MUL.
- valid_in=0 in IDLE: valid_out=0, and all other outputs hold their values.

## Timing
- Reset values: all outputs 0, FSM IDLE, lane counter 0, stall 0.
- Single-cycle ops (all scalar ops, vector non-MUL): inputs sampled at edge N; results, pass-throughs and valid_out=1 are visible after edge N.
- valid_out is a one-cycle pulse per instruction.
- Vector MUL accepted at edge N:
  - stall=1 after edges N..N+5 (6 cycles).
  - Result and valid_out=1 appear after edge N+6, with stall=0 from that edge on.
- A new instruction can be accepted at edge N+6.
- stall is a registered state decode (state==MUL) and has no combinational path from inputs.
- rst during MUL: operation aborted, no valid_out, FSM IDLE on the next edge.
- rst has priority over every other event.

## Configuration
- EXECUTE_SAT_EN defined: vector-mode ADD/SUB saturate unsigned per lane (clamp to 255 / 0); scalar stays wrap-around.
- EXECUTE_SAT_EN not defined: all ADD/SUB wrap modulo 256.

## Structure
- Shared package vp_exec_pkg holds:
  - alu_op_t enum (the 8 ops);
  - LANES, LANE_W and MUL_LPC constants;
  - exec field bit positions;
  - the exec_state_t enum.
- Sub-module vector_lane_alu: one combinational 8-bit lane ALU, with the EXECUTE_SAT_EN behaviour selected via an input. It is instantiated LANES times for vector mode and once for scalar.

## Test plan
- Scalar ADD with immediate:
  - Stimulus: r1e=0xF0, immALU=0x20, exec=5'b10000.
  - Required: res_s=0x10, valid_out=1 one edge later, mem/wb/dest passed through.
- Vector SUB:
  - Stimulus: every lane A=0x05, B=0x07.
  - Required: all lanes 0xFE without EXECUTE_SAT_EN, 0x00 with it; no borrow into the neighbouring lane.
- Vector SHL/SHR:
  - Stimulus: lane i of A=0x81, B=i.
  - Required: lane i equals (0x81<<(i&7))&0xFF and 0x81>>(i&7) respectively.
- Vector MUL:
  - Stimulus: lane i of A=i, B=3.
  - Required: stall high for 6 cycles; inputs changed during stall are ignored; after edge N+6 lane i=(3i)&0xFF and valid_out pulses once.
- Reset during MUL:
  - Stimulus: assert rst at the 3rd stall cycle.
  - Required: next edge gives all outputs 0, stall 0, no valid_out; the following scalar op completes normally.
- Bubble handling:
  - Stimulus: valid_in=0 with garbage operands.
  - Required: valid_out=0 and res_s/res_v unchanged.
